// File: rtl/pipe_scoreboard_if.sv
// ID-stage hazard/forwarding bundle between the decode stage and pipe_scoreboard.
// Pure wiring: the ID request and control inputs come from the master, and the stall/forward/debug results go back to it.
interface pipe_scoreboard_if #(
   parameter int NSTG = 3,
   parameter int RDYW = 2,
   parameter int CNTW = 32
);
   localparam int SELW = $clog2(NSTG + 1);

   logic            id_valid_i;
   logic            id_wen_i;
   logic [4:0]      id_rd_i;
   logic [RDYW-1:0] id_rdy_i;
   logic            id_rs1_en_i;
   logic            id_rs2_en_i;
   logic [4:0]      id_rs1_i;
   logic [4:0]      id_rs2_i;
   logic            hold_i;
   logic            flush_i;

   logic            stall_o;
   logic            bubble_o;
   logic [SELW-1:0] fwd1_sel_o;
   logic [SELW-1:0] fwd2_sel_o;
   logic [NSTG-1:0] slot_valid_o;
   logic [CNTW-1:0] cnt_hazard_o;
   logic [CNTW-1:0] cnt_hold_o;
   logic [CNTW-1:0] cnt_flush_o;

   modport master (
      output id_valid_i, id_wen_i, id_rd_i, id_rdy_i,
             id_rs1_en_i, id_rs2_en_i, id_rs1_i, id_rs2_i, hold_i, flush_i,
      input  stall_o, bubble_o, fwd1_sel_o, fwd2_sel_o, slot_valid_o,
             cnt_hazard_o, cnt_hold_o, cnt_flush_o
   );

   modport slave (
      input  id_valid_i, id_wen_i, id_rd_i, id_rdy_i,
             id_rs1_en_i, id_rs2_en_i, id_rs1_i, id_rs2_i, hold_i, flush_i,
      output stall_o, bubble_o, fwd1_sel_o, fwd2_sel_o, slot_valid_o,
             cnt_hazard_o, cnt_hold_o, cnt_flush_o
   );
endinterface

// File: rtl/pipe_scoreboard.sv
// Registered scoreboard for the post-decode stages: forward selects and the ID interlock are combinational from the slots.
// Slots advance one step per cycle, and hold_i freezes them; the oldest slot drops off with no back-pressure from WB.
module pipe_scoreboard #(
   parameter int NSTG     = 3,
   parameter int RDYW     = 2,
   parameter int FLUSH_EX = 0,
   parameter int CNTW     = 32
) (
   input logic               clk,
   input logic               rst,
   pipe_scoreboard_if.slave  sb
);
   localparam int SELW = $clog2(NSTG + 1);

   typedef struct packed {
      logic            valid;
      logic            wen;
      logic [4:0]      rd;
      logic [RDYW-1:0] rdy;
   } slot_t;

   typedef struct packed {
      logic            blk;
      logic [SELW-1:0] sel;
   } fwd_t;

   slot_t [NSTG-1:0] slot_q, slot_d;
   logic [CNTW-1:0]  cnt_hazard_q, cnt_hazard_d;
   logic [CNTW-1:0]  cnt_hold_q, cnt_hold_d;
   logic [CNTW-1:0]  cnt_flush_q, cnt_flush_d;

   fwd_t            fwd1, fwd2;
   logic            hazard;
   logic            bubble;
   logic [NSTG-1:0] slot_valid;

   // Scan from the oldest slot down, so the youngest match overwrites older ones.
   function automatic fwd_t lookup(input logic en, input logic [4:0] rs,
                                   input slot_t [NSTG-1:0] s);
      fwd_t r;
      r = '0;
      for (int k = NSTG - 1; k >= 0; k--) begin
         if (en && rs != 5'd0 && s[k].valid && s[k].wen && s[k].rd == rs) begin
            r.blk = (k < int'(s[k].rdy));
            r.sel = r.blk ? '0 : SELW'(k + 1);
         end
      end
      return r;
   endfunction

   always_comb begin
      fwd1   = lookup(sb.id_rs1_en_i, sb.id_rs1_i, slot_q);
      fwd2   = lookup(sb.id_rs2_en_i, sb.id_rs2_i, slot_q);
      hazard = sb.id_valid_i & ~sb.flush_i & (fwd1.blk | fwd2.blk);
      bubble = ~sb.hold_i & (hazard | sb.flush_i | ~sb.id_valid_i);
   end

   always_comb begin
      slot_d = slot_q;
      if (!sb.hold_i) begin
         for (int k = NSTG - 1; k >= 1; k--) begin
            slot_d[k] = slot_q[k-1];
         end
         // The squashed EX instruction is the wrong-path one behind the branch.
         if (FLUSH_EX != 0 && sb.flush_i) begin
            slot_d[1] = '0;
         end
         slot_d[0] = '0;
         if (!bubble) begin
            slot_d[0].valid = 1'b1;
            slot_d[0].wen   = sb.id_wen_i;
            slot_d[0].rd    = sb.id_rd_i;
            slot_d[0].rdy   = sb.id_rdy_i;
         end
      end
   end

   always_comb begin
      cnt_hazard_d = cnt_hazard_q;
      cnt_hold_d   = cnt_hold_q;
      cnt_flush_d  = cnt_flush_q;
      if (sb.hold_i) begin
         if (cnt_hold_q != '1) cnt_hold_d = cnt_hold_q + CNTW'(1);
      end else if (sb.flush_i) begin
         if (cnt_flush_q != '1) cnt_flush_d = cnt_flush_q + CNTW'(1);
      end else if (hazard) begin
         if (cnt_hazard_q != '1) cnt_hazard_d = cnt_hazard_q + CNTW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         slot_q       <= '0;
         cnt_hazard_q <= '0;
         cnt_hold_q   <= '0;
         cnt_flush_q  <= '0;
      end else begin
         slot_q       <= slot_d;
         cnt_hazard_q <= cnt_hazard_d;
         cnt_hold_q   <= cnt_hold_d;
         cnt_flush_q  <= cnt_flush_d;
      end
   end

   always_comb begin
      slot_valid = '0;
      for (int k = 0; k < NSTG; k++) begin
         slot_valid[k] = slot_q[k].valid;
      end
   end

   assign sb.stall_o      = hazard | sb.hold_i;
   assign sb.bubble_o     = bubble;
   assign sb.fwd1_sel_o   = fwd1.sel;
   assign sb.fwd2_sel_o   = fwd2.sel;
   assign sb.slot_valid_o = slot_valid;
   assign sb.cnt_hazard_o = cnt_hazard_q;
   assign sb.cnt_hold_o   = cnt_hold_q;
   assign sb.cnt_flush_o  = cnt_flush_q;
endmodule

// File: doc/pipe_scoreboard.md
# pipe_scoreboard

Parametrised hazard and forwarding controller for the pipelined miniRV core. It replaces the purely combinational load-use bubble logic with a registered scoreboard: one slot per post-decode stage, holding each in-flight instruction's destination register and the stage from which its result becomes forwardable. From this it drives the operand-forward selects and the interlock stall for the decode stage. It also supports a whole-pipe hold from slow memory, branch flush, and saturating performance counters.

## Interface
- NSTG, 3: number of post-ID stages tracked; slot 0 = EX, slot NSTG-1 = WB; legal 2..6
- RDYW, 2: width of per-instruction ready-stage field
- FLUSH_EX, 0: 1 = `flush_i` also squashes slot 0
- CNTW, 32: performance counter width
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- id_valid_i  in  1  valid instruction in ID
- id_wen_i  in  1  ID instruction writes rd
- id_rd_i  in  5  ID destination register
- id_rdy_i  in  RDYW  first slot index whose output may forward this result: 0 = ALU, 1 = load
- id_rs1_en_i, id_rs2_en_i  in  1  ID reads rs1 / rs2
- id_rs1_i, id_rs2_i  in  5  ID source registers
- hold_i  in  1  memory not ready; freeze the whole pipe
- flush_i  in  1  branch taken; kill the ID instruction
- stall_o  out  1  hold PC and IF/ID; hazard stall OR hold_i
- bubble_o  out  1  slot 0 loads a bubble this cycle
- fwd1_sel_o, fwd2_sel_o  out  $clog2(NSTG+1)  0 = regfile, k+1 = slot k result
- slot_valid_o  out  NSTG  valid bit per slot; MSB drives debug_wb_have_inst
- cnt_hazard_o, cnt_hold_o, cnt_flush_o  out  CNTW  event counters

## Operation
- Each slot holds valid, wen, rd[4:0] and rdy[RDYW-1:0].
- A slot matches source s when all of these hold: valid, wen, rd == s, s != 0, and the source enable is set.
- Per source, the youngest matching slot (lowest k) wins:
  - If k >= rdy: fwd_sel = k+1.
  - Otherwise the source is blocked.
  - If no slot matches: fwd_sel = 0.
- hazard = id_valid_i & !flush_i & (rs1 blocked | rs2 blocked).
- stall_o = hazard | hold_i.
- bubble_o = !hold_i & (hazard | flush_i | !id_valid_i).
- Slot update on each clock edge:
  - If hold_i: all slots unchanged.
  - Otherwise slot[k] <= slot[k-1] for k >= 1.
  - slot 0 <= ID instruction if !bubble_o, else invalid.
  - If FLUSH_EX=1 and flush_i: slot 1 takes an invalid entry instead of the old slot 0.
- Priority: hold_i > flush_i > hazard. flush_i is ignored while hold_i is high; the upstream stage keeps it asserted until the hold clears.
- Counters saturate at all-ones. On each cycle, only the highest-priority condition present increments its counter:
  - cnt_hold when hold_i.
  - else cnt_flush when flush_i.
  - else cnt_hazard when hazard.
- fwd/stall/bubble outputs are combinational from the current slots and ID inputs. No combinational path from hold_i to fwd_sel.

## Timing
- Reset (rst=0, asynchronous): all slot valid bits 0 and counters 0, so slot_valid_o=0. With id_valid_i=0, stall_o=0, bubble_o=1 and fwd_sel=0.
- ALU producer followed by a dependent instruction: zero stall cycles; fwd_sel=1.
- Load (rdy=1) immediately followed by a consumer:
  - Exactly one hazard cycle.
  - Next cycle: the load is in slot 1, slot 0 holds a bubble, fwd_sel=2.
- A result with rdy=r needs max(0, r-d) stall cycles, where d is the instruction distance minus 1.
- A producer in slot NSTG-1 (WB) forwards with sel=NSTG in the same cycle it writes the regfile.
- The oldest slot is dropped on advance; there is no back-pressure from WB.
- Reset mid-operation clears all in-flight entries immediately; no entry survives.

## Test plan
- Reset: assert rst=0 mid-run with slots full → slot_valid_o=0 and counters=0 immediately; after release, fwd_sel=0 for any rs.
- ALU chain: issue x5=ALU(rdy=0), then a consumer of rs1=x5 → stall_o=0 and fwd1_sel=1. One cycle later, a consumer of x5 (no newer writer) → fwd1_sel=2.
- Load-use: issue load x6 (rdy=1), then a consumer of rs2=x6 → stall_o=1, bubble_o=1 for 1 cycle, cnt_hazard=1. The next cycle shows fwd2_sel=2.
- Youngest-wins and x0: slots 0 and 2 both write x7 → fwd_sel=1. A writer to x0 never matches, so fwd_sel=0.
- Hold: with a load-use pending, hold_i=1 for 3 cycles → slots frozen, stall_o=1, cnt_hold=3, cnt_hazard unchanged. After release, exactly one hazard cycle.
- Flush with FLUSH_EX=1: flush_i together with a hazard → bubble_o=1, stall_o=0, cnt_flush+1. Next cycle slot_valid_o[1:0]=00.
